// File: rtl/frame_stream_pkg.sv
// Shared types and sizing helpers for the frame-buffer raster streamer.
package frame_stream_pkg;

    typedef enum logic [2:0] {IDLE, ACTIVE, HBLANK, DRAIN, DONE} fs_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int frame_pix(input int w, input int h);
        return w * h;
    endfunction

    function automatic int blank_w(input int hblank);
        return cnt_w(hblank + 1);
    endfunction

endpackage

// File: rtl/frame_streamer.sv
// Raster-scan reader: walks a frame buffer line by line, inserts a blanking gap
// between lines, and streams the returned pixels with sof/eol/done markers.
module frame_streamer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    parameter int HBLANK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_out,
    output logic              pixel_vld,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done
);
    // Imported in the body so the HBLANK parameter shadows the state literal.
    import frame_stream_pkg::*;

    localparam int COL_W   = cnt_w(IMG_W);
    localparam int ROW_W   = cnt_w(IMG_H);
    localparam int BLANK_W = blank_w(HBLANK);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(HBLANK - 1);

    fs_state_e          state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               issue;
    logic               rd_first_q, rd_last_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        blank_d = blank_q;
        issue   = 1'b0;

        unique case (state_q)
            IDLE: begin
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
                // busy is still high on the cycle after DONE; a start there is dropped.
                if (start && !busy) begin
                    state_d = ACTIVE;
                    issue   = !hold;
                end
            end
            ACTIVE: issue = !hold;
            frame_stream_pkg::HBLANK: begin
                if (blank_q == BLANK_LAST) begin
                    blank_d = '0;
                    state_d = ACTIVE;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    row_d   = row_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = (HBLANK > 0) ? frame_stream_pkg::HBLANK : ACTIVE;
                end
            end else begin
                col_d  = col_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // NOTE: state and outputs update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            blank_q    <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            pixel_vld  <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            blank_q    <= blank_d;
            mem_rd_en  <= issue;
            if (issue) mem_addr <= addr_q;
            rd_first_q <= issue && (addr_q == '0);
            rd_last_q  <= issue && (col_q == COL_LAST);
            pixel_vld  <= mem_rd_en;
            sof        <= rd_first_q;
            eol        <= rd_last_q;
            busy       <= (state_d != IDLE) || (state_q == DONE);
            done       <= (state_q == DONE);
        end
    end

    // The RAM's output register is the pixel stage; gating keeps pixel_out at 0 between pixels.
    assign pixel_out = pixel_vld ? mem_rdata : '0;

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench: 4x3 frames with and without blanking, hold, restart, reset abort, full 32x32.
module tb_frame_streamer;

    typedef struct {
        int   cyc;
        int   val;
        logic sof;
        logic eol;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: 4x3, HBLANK=2 ----------------
    logic       a_start = 1'b0, a_hold = 1'b0;
    logic       a_rd_en, a_vld, a_sof, a_eol, a_busy, a_done;
    logic [3:0] a_addr;
    logic [7:0] a_rdata = 8'h00, a_pix;
    logic [7:0] a_mem [12];

    frame_streamer #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .ADDR_W(4), .HBLANK(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .hold(a_hold),
        .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .pixel_out(a_pix), .pixel_vld(a_vld), .sof(a_sof), .eol(a_eol),
        .busy(a_busy), .done(a_done));

    // ---------------- instance B: 4x3, HBLANK=0 ----------------
    logic       b_start = 1'b0, b_hold = 1'b0;
    logic       b_rd_en, b_vld, b_sof, b_eol, b_busy, b_done;
    logic [3:0] b_addr;
    logic [7:0] b_rdata = 8'h00, b_pix;

    frame_streamer #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .ADDR_W(4), .HBLANK(0)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .hold(b_hold),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .pixel_out(b_pix), .pixel_vld(b_vld), .sof(b_sof), .eol(b_eol),
        .busy(b_busy), .done(b_done));

    // ---------------- instance C: default 32x32 ----------------
    logic       c_start = 1'b0, c_hold = 1'b0;
    logic       c_rd_en, c_vld, c_sof, c_eol, c_busy, c_done;
    logic [9:0] c_addr;
    logic [7:0] c_rdata = 8'h00, c_pix;

    frame_streamer u_c (
        .clk(clk), .rst(rst), .start(c_start), .hold(c_hold),
        .mem_rd_en(c_rd_en), .mem_addr(c_addr), .mem_rdata(c_rdata),
        .pixel_out(c_pix), .pixel_vld(c_vld), .sof(c_sof), .eol(c_eol),
        .busy(c_busy), .done(c_done));

    initial for (int i = 0; i < 12; i++) a_mem[i] = 8'(i + 16);

    // Synchronous RAMs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= a_mem[a_addr];
        if (b_rd_en) b_rdata <= a_mem[b_addr];
        if (c_rd_en) c_rdata <= c_addr[7:0];
    end

    ev_t a_rd[$], a_px[$], b_rd[$], b_px[$], c_rd[$], c_px[$];
    int  a_dn[$], b_dn[$], c_dn[$];
    int  a_stray = 0, b_stray = 0, c_stray = 0;

    always @(negedge clk) begin
        if (a_rd_en) a_rd.push_back('{cyc, int'(a_addr), 1'b0, 1'b0});
        if (a_vld)   a_px.push_back('{cyc, int'(a_pix), a_sof, a_eol});
        if (a_done)  a_dn.push_back(cyc);
        if ((a_sof || a_eol) && !a_vld) a_stray <= a_stray + 1;
        if (b_rd_en) b_rd.push_back('{cyc, int'(b_addr), 1'b0, 1'b0});
        if (b_vld)   b_px.push_back('{cyc, int'(b_pix), b_sof, b_eol});
        if (b_done)  b_dn.push_back(cyc);
        if ((b_sof || b_eol) && !b_vld) b_stray <= b_stray + 1;
        if (c_rd_en) c_rd.push_back('{cyc, int'(c_addr), 1'b0, 1'b0});
        if (c_vld)   c_px.push_back('{cyc, int'(c_pix), c_sof, c_eol});
        if (c_done)  c_dn.push_back(cyc);
        if ((c_sof || c_eol) && !c_vld) c_stray <= c_stray + 1;
    end

    task automatic clear_a();
        @(negedge clk);
        a_rd.delete(); a_px.delete(); a_dn.delete(); a_stray = 0;
    endtask

    task automatic test_reset();
        logic [7:0] got [10];
        repeat (2) @(negedge clk);
        got = '{8'(a_rd_en), 8'(a_addr), a_pix, 8'(a_vld), 8'(a_sof), 8'(a_eol),
                8'(a_busy), 8'(a_done), 8'(b_rd_en), 8'(b_busy)};
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_out[%0d] got=%0h want=0", i, got[i]);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_rd_en !== 1'b0 || a_busy !== 1'b0 || a_vld !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset rd=%b busy=%b vld=%b want=000", a_rd_en, a_busy, a_vld);
        end
    endtask

    task automatic test_frame();
        int t0, r, c, e;
        clear_a();
        t0 = cyc; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (24) begin
            e = (cyc >= t0 + 1 && cyc <= t0 + 18) ? 1 : 0;
            checks++;
            if (a_busy !== e[0]) begin
                failures++;
                $display("FAIL frame_busy cyc=T+%0d got=%b want=%0d", cyc - t0, a_busy, e);
            end
            @(negedge clk);
        end
        checks++;
        if (a_rd.size() != 12 || a_px.size() != 12) begin
            failures++;
            $display("FAIL frame_count reads=%0d pixels=%0d want=12/12", a_rd.size(), a_px.size());
        end
        for (int i = 0; i < 12 && i < a_rd.size() && i < a_px.size(); i++) begin
            r = i / 4; c = i % 4;
            e = t0 + 1 + r * 6 + c;
            checks++;
            if (a_rd[i].cyc != e || a_rd[i].val != i) begin
                failures++;
                $display("FAIL frame_rd[%0d] got addr=%0d@T+%0d want addr=%0d@T+%0d",
                         i, a_rd[i].val, a_rd[i].cyc - t0, i, e - t0);
            end
            checks++;
            if (a_px[i].cyc != e + 1 || a_px[i].val != i + 16 ||
                a_px[i].sof !== (i == 0) || a_px[i].eol !== (c == 3)) begin
                failures++;
                $display("FAIL frame_px[%0d] got %0d@T+%0d sof=%b eol=%b want %0d@T+%0d sof=%0d eol=%0d",
                         i, a_px[i].val, a_px[i].cyc - t0, a_px[i].sof, a_px[i].eol,
                         i + 16, e + 1 - t0, (i == 0), (c == 3));
            end
        end
        checks++;
        if (a_dn.size() != 1 || (a_dn.size() == 1 && a_dn[0] != t0 + 18) || a_stray != 0) begin
            failures++;
            $display("FAIL frame_done count=%0d first=T+%0d stray=%0d want 1 at T+18, stray 0",
                     a_dn.size(), (a_dn.size() > 0) ? a_dn[0] - t0 : -1, a_stray);
        end
    endtask

    task automatic test_hblank0();
        int t0;
        @(negedge clk);
        b_rd.delete(); b_px.delete(); b_dn.delete(); b_stray = 0;
        t0 = cyc; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (b_px.size() != 12) begin
            failures++;
            $display("FAIL hb0_count got=%0d want=12", b_px.size());
        end
        for (int i = 0; i < 12 && i < b_px.size(); i++) begin
            checks++;
            if (b_px[i].cyc != t0 + 2 + i || b_px[i].val != i + 16 ||
                b_px[i].eol !== (i % 4 == 3) || b_px[i].sof !== (i == 0)) begin
                failures++;
                $display("FAIL hb0_px[%0d] got %0d@T+%0d eol=%b sof=%b want %0d@T+%0d eol=%0d sof=%0d",
                         i, b_px[i].val, b_px[i].cyc - t0, b_px[i].eol, b_px[i].sof,
                         i + 16, i + 2, (i % 4 == 3), (i == 0));
            end
        end
        checks++;
        if (b_dn.size() != 1 || (b_dn.size() == 1 && b_dn[0] != t0 + 14)) begin
            failures++;
            $display("FAIL hb0_done count=%0d at=T+%0d want 1 at T+14",
                     b_dn.size(), (b_dn.size() > 0) ? b_dn[0] - t0 : -1);
        end
    endtask

    task automatic test_hold();
        int t0;
        clear_a();
        t0 = cyc; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (26) begin
            // Line 1 col 2 held 3 cycles, plus holds during HBLANK and DRAIN.
            a_hold = (cyc >= t0 + 8 && cyc <= t0 + 10) || cyc == t0 + 13 ||
                     cyc == t0 + 14 || cyc == t0 + 19;
            @(negedge clk);
        end
        a_hold = 1'b0;
        checks++;
        if (a_rd.size() != 12 || a_px.size() != 12) begin
            failures++;
            $display("FAIL hold_count reads=%0d pixels=%0d want=12/12", a_rd.size(), a_px.size());
        end
        for (int i = 0; i < 12 && i < a_px.size(); i++) begin
            checks++;
            if (a_px[i].val != i + 16) begin
                failures++;
                $display("FAIL hold_px[%0d] got=%0d want=%0d", i, a_px[i].val, i + 16);
            end
        end
        if (a_rd.size() == 12) begin
            checks++;
            if (a_rd[6].cyc - a_rd[5].cyc != 4 || a_rd[6].cyc != t0 + 12 || a_rd[8].cyc != t0 + 16) begin
                failures++;
                $display("FAIL hold_gap rd6=T+%0d rd8=T+%0d gap=%0d want T+12, T+16, 4",
                         a_rd[6].cyc - t0, a_rd[8].cyc - t0, a_rd[6].cyc - a_rd[5].cyc);
            end
        end
        checks++;
        if (a_dn.size() != 1 || (a_dn.size() == 1 && a_dn[0] != t0 + 21)) begin
            failures++;
            $display("FAIL hold_done count=%0d at=T+%0d want 1 at T+21",
                     a_dn.size(), (a_dn.size() > 0) ? a_dn[0] - t0 : -1);
        end
    endtask

    task automatic test_restart_ignored();
        int t0;
        clear_a();
        t0 = cyc; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (28) begin
            a_start = (cyc == t0 + 5) || (cyc == t0 + 17) || (cyc == t0 + 18);
            @(negedge clk);
        end
        a_start = 1'b0;
        checks++;
        if (a_rd.size() != 12 || a_px.size() != 12 || a_dn.size() != 1) begin
            failures++;
            $display("FAIL ignore_start reads=%0d pixels=%0d dones=%0d want 12/12/1",
                     a_rd.size(), a_px.size(), a_dn.size());
        end
        clear_a();
        t0 = cyc; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_rd.size() < 1 || a_px.size() < 1 || a_rd[0].val != 0 || a_rd[0].cyc != t0 + 1 ||
            a_px[0].sof !== 1'b1 || a_px[0].cyc != t0 + 2 || a_px[0].val != 16) begin
            failures++;
            $display("FAIL restart_first reads=%0d pixels=%0d want addr0@T+1, sof pixel 16@T+2",
                     a_rd.size(), a_px.size());
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t0, late;
        clear_a();
        t0 = cyc; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        while (cyc < t0 + 9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_rd_en, a_addr, a_pix, a_vld, a_sof, a_eol, a_busy, a_done} !== 18'h0) begin
            failures++;
            $display("FAIL rst_mid_out got rd=%b addr=%0d pix=%0d vld=%b busy=%b done=%b want all 0",
                     a_rd_en, a_addr, a_pix, a_vld, a_busy, a_done);
        end
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        late = 0;
        foreach (a_rd[i]) if (a_rd[i].cyc > t0 + 9) late++;
        checks++;
        if (a_dn.size() != 0 || late != 0 || a_px.size() != 6) begin
            failures++;
            $display("FAIL rst_mid_abort dones=%0d late_reads=%0d pixels=%0d want 0/0/6",
                     a_dn.size(), late, a_px.size());
        end
        clear_a();
        t0 = cyc; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (22) @(negedge clk);
        checks++;
        if (a_px.size() != 12 || a_dn.size() != 1) begin
            failures++;
            $display("FAIL rst_mid_refill pixels=%0d dones=%0d want 12/1", a_px.size(), a_dn.size());
        end
        for (int i = 0; i < a_px.size() && i < 12; i++) begin
            checks++;
            if (a_px[i].val != i + 16 || a_px[i].sof !== (i == 0)) begin
                failures++;
                $display("FAIL rst_mid_px[%0d] got=%0d sof=%b want=%0d sof=%0d",
                         i, a_px[i].val, a_px[i].sof, i + 16, (i == 0));
            end
        end
    endtask

    task automatic test_full_frame();
        int budget, max_addr, eols, sofs, bad_px, bad_eol;
        @(negedge clk);
        c_rd.delete(); c_px.delete(); c_dn.delete(); c_stray = 0;
        c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        budget = 0;
        while (c_dn.size() == 0 && budget < 1500) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (c_dn.size() == 0) begin
            failures++;
            $display("FAIL full_timeout no done within %0d cycles", budget);
        end
        repeat (4) @(negedge clk);
        max_addr = 0; eols = 0; sofs = 0; bad_px = 0; bad_eol = 0;
        foreach (c_rd[i]) begin
            if (c_rd[i].val > max_addr) max_addr = c_rd[i].val;
            if (c_rd[i].val != i) bad_px++;
        end
        foreach (c_px[i]) begin
            if (c_px[i].val != (i % 256)) bad_px++;
            if (c_px[i].eol) eols++;
            if (c_px[i].sof) sofs++;
            if (c_px[i].eol !== (i % 32 == 31)) bad_eol++;
        end
        checks++;
        if (c_px.size() != 1024 || c_rd.size() != 1024 || max_addr != 1023) begin
            failures++;
            $display("FAIL full_count pixels=%0d reads=%0d max_addr=%0d want 1024/1024/1023",
                     c_px.size(), c_rd.size(), max_addr);
        end
        checks++;
        if (bad_px != 0 || bad_eol != 0 || eols != 32 || sofs != 1 || c_dn.size() != 1 || c_stray != 0) begin
            failures++;
            $display("FAIL full_markers bad_px=%0d bad_eol=%0d eol=%0d sof=%0d done=%0d stray=%0d want 0/0/32/1/1/0",
                     bad_px, bad_eol, eols, sofs, c_dn.size(), c_stray);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_hblank0();
        test_hold();
        test_restart_ignored();
        test_reset_mid();
        test_full_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
